// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry (main + skid) buffer.
// in_ready is registered so upstream never sees a combinational path from
// out_ready; the skid entry absorbs the one entry that can arrive while the
// downstream stalls. Flush squashes both entries, and a saturating counter
// records cycles in which downstream was ready but no entry was offered.
module pipe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int CTRL_W     = 16,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam bit FLUSH_CLEARS_DATA = (CLEAR_DATA != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              in_ready_reg;
  logic [WIDTH-1:0]  main_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [WIDTH-1:0]  skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [CNT_W-1:0]  bubble_reg;

  logic in_fire;
  logic out_fire;
  logic load_main;      // main captures a new entry this edge
  logic main_from_skid; // that entry comes from skid rather than upstream
  logic load_skid;      // skid captures the upstream entry this edge

  assign out_valid = (state_reg != ST_EMPTY);
  assign in_ready  = in_ready_reg;
  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid & out_ready;

  // Head entry drives the outputs; control is forced to zero when no entry is
  // presented, so a stale control word left behind after a pop never leaks out.
  assign out_data   = main_data_reg;
  assign out_ctrl   = out_valid ? main_ctrl_reg : '0;
  assign bubble_cnt = bubble_reg;

  // Next-state and storage-load decode for the EMPTY/ONE/FULL occupancy FSM.
  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (out_fire) begin
          state_next     = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Occupancy state and the registered ready; reset beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else if (flush) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

  // Control fields of both entries; always zeroed on flush so squashed
  // instructions cannot cause side effects downstream.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      if (load_main) begin
        main_ctrl_reg <= main_from_skid ? skid_ctrl_reg : in_ctrl;
      end
      if (load_skid) begin
        skid_ctrl_reg <= in_ctrl;
      end
    end
  end

  // Payload of both entries; cleared on reset, and on flush only when the
  // CLEAR_DATA build option asks for it (otherwise held to save toggling).
  always_ff @(posedge clk) begin
    if (reset || (flush && FLUSH_CLEARS_DATA)) begin
      main_data_reg <= '0;
      skid_data_reg <= '0;
    end else if (!flush) begin
      if (load_main) begin
        main_data_reg <= main_from_skid ? skid_data_reg : in_data;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
      end
    end
  end

  // Saturating count of cycles where downstream was ready but got no entry;
  // only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_reg <= '0;
    end else if (!out_valid && out_ready && (bubble_reg != CNT_MAX)) begin
      bubble_reg <= bubble_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue-based reference model is
// updated at each edge and every DUT output is compared against it #1 later.
// Two instances share the stimulus and differ only in CLEAR_DATA.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [15:0] out_ctrl0, out_ctrl1;
  logic [3:0]  bubble_cnt0, bubble_cnt1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
  } entry_t;

  entry_t     sb_q[$];
  logic [3:0] m_bub = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .CTRL_W(16), .CLEAR_DATA(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .bubble_cnt(bubble_cnt0)
  );

  pipe_stage_reg #(.WIDTH(32), .CTRL_W(16), .CLEAR_DATA(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .bubble_cnt(bubble_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model state.
  task automatic check_all(input string tag);
    logic        exp_valid;
    logic [15:0] exp_ctrl;
    exp_valid = (sb_q.size() > 0);
    exp_ctrl  = exp_valid ? sb_q[0].c : 16'h0;
    check({tag, " out_valid0"}, out_valid0, exp_valid);
    check({tag, " in_ready0"},  in_ready0,  sb_q.size() < 2);
    check({tag, " out_ctrl0"},  out_ctrl0,  exp_ctrl);
    check({tag, " bubble0"},    bubble_cnt0, m_bub);
    check({tag, " out_valid1"}, out_valid1, exp_valid);
    check({tag, " in_ready1"},  in_ready1,  sb_q.size() < 2);
    check({tag, " out_ctrl1"},  out_ctrl1,  exp_ctrl);
    check({tag, " bubble1"},    bubble_cnt1, m_bub);
    if (exp_valid) begin
      check({tag, " out_data0"}, out_data0, sb_q[0].d);
      check({tag, " out_data1"}, out_data1, sb_q[0].d);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic step(input string tag, input bit rst, input bit fl, input bit iv,
                      input logic [31:0] d, input logic [15:0] c, input bit ordy);
    bit     pre_valid, pre_ready;
    entry_t e;
    reset = rst; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    pre_valid = (sb_q.size() > 0);
    pre_ready = (sb_q.size() < 2);
    @(posedge clk);
    if (rst) begin
      m_bub = '0;
    end else if (!pre_valid && ordy && m_bub != 4'hF) begin
      m_bub = m_bub + 4'd1;
    end
    if (rst || fl) begin
      sb_q.delete();
    end else begin
      if (pre_valid && ordy) begin
        e = sb_q.pop_front();
        $display("pop  data=%08h ctrl=%04h", e.d, e.c);
      end
      if (iv && pre_ready) begin
        e.d = d;
        e.c = c;
        sb_q.push_back(e);
        $display("push data=%08h ctrl=%04h", d, c);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state
    step("reset", 1, 0, 0, 32'h0, 16'h0, 0);
    step("reset", 1, 1, 1, 32'h55, 16'h5, 1);
    check("reset out_data0", out_data0, 32'h0);
    check("reset out_data1", out_data1, 32'h0);

    // Streaming at one entry per cycle
    for (int i = 1; i <= 8; i++) begin
      step("stream", 0, 0, 1, i, 16'(i), 1);
    end
    step("stream drain", 0, 0, 0, 32'h0, 16'h0, 1);

    // Backpressure: two entries with out_ready low, then release
    step("bp load A", 0, 0, 1, 32'hA, 16'h0A0A, 0);
    step("bp load B", 0, 0, 1, 32'hB, 16'h0B0B, 0);
    check("bp full in_ready", in_ready0, 1'b0);
    step("bp blocked C", 0, 0, 1, 32'hC, 16'h0C0C, 0);
    step("bp hold", 0, 0, 0, 32'h0, 16'h0, 0);
    step("bp pop A", 0, 0, 0, 32'h0, 16'h0, 1);
    check("bp ready after pop", in_ready0, 1'b1);
    step("bp pop B", 0, 0, 0, 32'h0, 16'h0, 1);

    // Flush in FULL with an incoming entry
    step("fl load1", 0, 0, 1, 32'h11, 16'h1111, 0);
    step("fl load2", 0, 0, 1, 32'h22, 16'h2222, 0);
    step("fl full", 0, 1, 1, 32'h33, 16'hFFFF, 1);
    check("fl ctrl zero", out_ctrl0, 16'h0000);

    // CLEAR_DATA 0 vs 1: flush in ONE, incoming entry accepted-but-squashed
    step("cd load", 0, 0, 1, 32'hDEADBEEF, 16'h0F0F, 0);
    step("cd flush", 0, 1, 1, 32'h12345678, 16'hFFFF, 0);
    check("cd held data", out_data0, 32'hDEADBEEF);
    check("cd cleared data", out_data1, 32'h00000000);
    step("cd idle", 0, 0, 0, 32'h0, 16'h0, 0);

    // Bubble counter saturation
    for (int i = 0; i < 20; i++) begin
      step("bubble", 0, 0, 0, 32'h0, 16'h0, 1);
    end
    check("bubble sat", bubble_cnt0, 4'd15);
    step("bubble flush keeps", 0, 1, 0, 32'h0, 16'h0, 0);

    // Reset during FULL together with flush
    step("rf load1", 0, 0, 1, 32'h77, 16'h7777, 0);
    step("rf load2", 0, 0, 1, 32'h88, 16'h8888, 0);
    step("rf reset", 1, 1, 1, 32'h99, 16'h9999, 1);
    check("rf bubble zero", bubble_cnt0, 4'd0);
    step("rf first", 0, 0, 1, 32'hAB, 16'h00AB, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 1) == 1, $urandom, 16'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
